// File: rtl/toggle_event_rx.sv
// Receive end of a toggle-signalled event link: synchronises t_in, turns each level change into one
// event, queues events in a saturating pending counter. Optional macro: TOGGLE_RX_GLITCH_FILTER_EN.
module toggle_event_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int PEND_W      = 4,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              t_in,
    output logic              evt_pulse,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [PEND_W-1:0] pend_cnt,
    output logic [CNT_W-1:0]  total_cnt,
    output logic              overflow,
    input  logic              clr_ovf
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
    localparam logic [2:0]        INIT_LAST = 3'(SYNC_STAGES);

    state_t              state_r;
    logic [2:0]          init_cnt_r;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                ref_r;
    logic                evt_pulse_r;
    logic                evt_valid_r;
    logic [PEND_W-1:0]   pend_cnt_r;
    logic [CNT_W-1:0]    total_cnt_r;
    logic                overflow_r;
`ifdef TOGGLE_RX_GLITCH_FILTER_EN
    logic                sync_d_r;
`endif

    logic                sync_out_s;
    logic                edge_s;
    logic                accept_s;
    logic                consume_s;
    logic                loss_s;
    logic [PEND_W-1:0]   pend_nxt_s;

    assign sync_out_s = sync_r[SYNC_STAGES-1];

    // Edge detection and next pending count; a full counter drops the event unless a consume frees a slot
    always_comb begin
        edge_s     = 1'b0;
        accept_s   = 1'b0;
        consume_s  = 1'b0;
        loss_s     = 1'b0;
        pend_nxt_s = pend_cnt_r;
`ifdef TOGGLE_RX_GLITCH_FILTER_EN
        edge_s = (sync_out_s != ref_r) && (sync_out_s == sync_d_r);
`else
        edge_s = (sync_out_s != ref_r);
`endif
        if (state_r == ST_RUN) begin
            accept_s = edge_s;
        end else begin
            accept_s = 1'b0;
        end
        consume_s = evt_valid_r && evt_ready;
        case ({accept_s, consume_s})
            2'b10: begin
                if (pend_cnt_r == PEND_MAX) begin
                    loss_s = 1'b1;
                end else begin
                    pend_nxt_s = pend_cnt_r + PEND_W'(1);
                end
            end
            2'b01:   pend_nxt_s = pend_cnt_r - PEND_W'(1);
            default: pend_nxt_s = pend_cnt_r;
        endcase
    end

    // Synchroniser, INIT/RUN sequencing and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_INIT;
            init_cnt_r  <= 3'd0;
            sync_r      <= {SYNC_STAGES{1'b0}};
            ref_r       <= 1'b0;
            evt_pulse_r <= 1'b0;
            evt_valid_r <= 1'b0;
            pend_cnt_r  <= {PEND_W{1'b0}};
            total_cnt_r <= {CNT_W{1'b0}};
            overflow_r  <= 1'b0;
`ifdef TOGGLE_RX_GLITCH_FILTER_EN
            sync_d_r    <= 1'b0;
`endif
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], t_in};
`ifdef TOGGLE_RX_GLITCH_FILTER_EN
            sync_d_r <= sync_out_s;
`endif
            case (state_r)
                ST_INIT: begin
                    // The line level seen while the chain fills is adopted, never counted
                    ref_r <= sync_out_s;
                    if (init_cnt_r == INIT_LAST) begin
                        state_r <= ST_RUN;
                    end else begin
                        init_cnt_r <= init_cnt_r + 3'd1;
                    end
                end
                ST_RUN: begin
                    if (accept_s) begin
                        ref_r <= sync_out_s;
                    end else begin
                        ref_r <= ref_r;
                    end
                end
                default: begin
                    state_r    <= ST_INIT;
                    init_cnt_r <= 3'd0;
                end
            endcase
            evt_pulse_r <= accept_s;
            pend_cnt_r  <= pend_nxt_s;
            evt_valid_r <= (pend_nxt_s != {PEND_W{1'b0}});
            if (accept_s) begin
                total_cnt_r <= total_cnt_r + CNT_W'(1);
            end else begin
                total_cnt_r <= total_cnt_r;
            end
            if (loss_s) begin
                overflow_r <= 1'b1;
            end else if (clr_ovf) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign evt_pulse = evt_pulse_r;
    assign evt_valid = evt_valid_r;
    assign pend_cnt  = pend_cnt_r;
    assign total_cnt = total_cnt_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_toggle_event_rx.sv
// Scoreboard bench for toggle_event_rx: each driven toggle pushes its expected pulse cycle,
// the negedge monitor pops and compares; counters are checked against bench-tracked totals.
module tb_toggle_event_rx;

    localparam int SYNC_STAGES = 2;
    localparam int PEND_W      = 4;
    localparam int CNT_W       = 8;
`ifdef TOGGLE_RX_GLITCH_FILTER_EN
    localparam int LAT = SYNC_STAGES + 1;
`else
    localparam int LAT = SYNC_STAGES;
`endif

    logic              clk;
    logic              rst_n;
    logic              t_in;
    logic              evt_pulse;
    logic              evt_valid;
    logic              evt_ready;
    logic [PEND_W-1:0] pend_cnt;
    logic [CNT_W-1:0]  total_cnt;
    logic              overflow;
    logic              clr_ovf;

    int checks;
    int errors;
    int cyc;
    int exp_total;
    int exp_q[$];

    toggle_event_rx #(
        .SYNC_STAGES(SYNC_STAGES),
        .PEND_W     (PEND_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .t_in     (t_in),
        .evt_pulse(evt_pulse),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .pend_cnt (pend_cnt),
        .total_cnt(total_cnt),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts rising edges; after edge k the value is k
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    // Pulse monitor: every pulse must match the oldest expected pulse cycle
    always @(negedge clk) begin
        if (evt_pulse === 1'b1) begin
            if (exp_q.size() > 0) begin
                check("pulse_cyc", cyc, exp_q.pop_front());
            end else begin
                check("spurious_pulse", int'(evt_pulse), 0);
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Flip the line at a negedge; it is sampled at the next rising edge
    task automatic toggle();
        @(negedge clk);
        t_in = ~t_in;
        exp_q.push_back(cyc + 1 + LAT);
        exp_total++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pulse"}, int'(evt_pulse), 0);
        check({tag, "_valid"}, int'(evt_valid), 0);
        check({tag, "_pend"},  int'(pend_cnt), 0);
        check({tag, "_total"}, int'(total_cnt), 0);
        check({tag, "_ovf"},   int'(overflow), 0);
    endtask

    initial begin
        int pend_seq[5];
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        exp_total = 0;
        rst_n     = 1'b0;
        t_in      = 1'b1;
        evt_ready = 1'b0;
        clr_ovf   = 1'b0;

        // 1: reset with line high; the initial level is never an event
        idle(3);
        check_all_zero("rst");
        rst_n = 1'b1;
        idle(10);
        check("t1_pend", int'(pend_cnt), 0);
        check("t1_total", int'(total_cnt), 0);

        // 2: three toggles six cycles apart, no consumer
        for (int i = 0; i < 3; i++) begin
            toggle();
            idle(5);
        end
        check("t2_pend", int'(pend_cnt), 3);
        check("t2_total", int'(total_cnt), exp_total);
        check("t2_valid", int'(evt_valid), 1);

        // 3: drain with a toggle landing mid-drain
`ifdef TOGGLE_RX_GLITCH_FILTER_EN
        pend_seq = '{2, 1, 0, 1, 0};
`else
        pend_seq = '{2, 1, 1, 0, 0};
`endif
        toggle();
        evt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_pend", int'(pend_cnt), pend_seq[i]);
            check("t3_valid", int'(evt_valid), int'(pend_seq[i] != 0));
        end
        evt_ready = 1'b0;
        check("t3_total", int'(total_cnt), exp_total);

        // 4: sixteen toggles into a 15-deep counter
        for (int i = 0; i < 16; i++) begin
            toggle();
            idle(2);
        end
        idle(LAT + 2);
        check("t4_pend", int'(pend_cnt), 15);
        check("t4_ovf", int'(overflow), 1);
        check("t4_total", int'(total_cnt), exp_total % 256);
        @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("t4_ovf_clr", int'(overflow), 0);
        check("t4_pend_hold", int'(pend_cnt), 15);

        // 5: 256 toggles while consuming; total wraps back to its start value
        evt_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            toggle();
            idle(2);
        end
        idle(LAT + 20);
        check("t5_total", int'(total_cnt), exp_total % 256);
        check("t5_pend", int'(pend_cnt), 0);
        check("t5_ovf", int'(overflow), 0);
        evt_ready = 1'b0;

        // 6: build five pending events, then a one-cycle reset
        for (int i = 0; i < 5; i++) begin
            toggle();
            idle(2);
        end
        idle(LAT + 2);
        check("t6_pend", int'(pend_cnt), 5);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_total = 0;
        check_all_zero("t6_rst");
        idle(10);
        check("t6_init_pend", int'(pend_cnt), 0);
        toggle();
        idle(LAT + 3);
        check("t6_post_pend", int'(pend_cnt), 1);
        check("t6_post_total", int'(total_cnt), exp_total);

`ifdef TOGGLE_RX_GLITCH_FILTER_EN
        // One-cycle excursion must be filtered out
        @(negedge clk);
        t_in = ~t_in;
        @(negedge clk);
        t_in = ~t_in;
        idle(LAT + 4);
        check("glitch_total", int'(total_cnt), exp_total);
`endif

        idle(4);
        check("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
